// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP read sequencer: FSM encoding,
// default aux-channel addresses and DRP bus widths.
package xadc_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_WAIT_EOC  = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DRDY = 2'd2
  } seq_state_t;

  // Default aux channels: VAUX3 (0x13) feeds V1, VAUX11 (0x1B) feeds V2
  localparam logic [7:0] DEF_ADDR_A = 8'h13;
  localparam logic [7:0] DEF_ADDR_B = 8'h1B;

  // DRP bus widths
  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  // Saturation limit of the timeout counter
  localparam logic [7:0] ERR_MAX = 8'hFF;

  // Alternate between the two channels; anything unexpected restarts at A
  function automatic logic [7:0] other_chan(input logic [7:0] cur,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    return (cur == a) ? b : a;
  endfunction

endpackage

// File: rtl/drp_watchdog.sv
// DRDY watchdog: cleared when a read is issued, counts every busy cycle and
// flags expiry once TIMEOUT-1 counts have elapsed since the clear.
module drp_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_count;

  // Counter: clear has priority, then count up and hold at the last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == LAST);

endmodule

// File: rtl/xadc_drp_sequencer.sv
// XADC DRP read sequencer: on each end-of-conversion reads the current aux
// channel over DRP, alternating between ADDR_A and ADDR_B, guards the read
// with a watchdog and presents the captured word with a one-cycle strobe.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter logic [7:0] ADDR_A  = DEF_ADDR_A,
  parameter logic [7:0] ADDR_B  = DEF_ADDR_B,
  parameter int         TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              eoc_in,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [DRP_AW-1:0] drp_daddr,
  output logic [DRP_DW-1:0] drp_di,
  input  logic [DRP_DW-1:0] drp_do,
  input  logic              drp_drdy,
  output logic [DRP_DW-1:0] data_out,
  output logic [7:0]        data_addr,
  output logic              data_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        err_count,
  output logic              overrun
);

  // FSM and bookkeeping state
  seq_state_t r_state;
  seq_state_t w_state_next;
  logic [7:0] r_chan;
  logic [7:0] w_chan_next;
  logic       r_pending;
  logic       w_pending_next;

  // Registered outputs and their next values
  logic              r_den,        w_den_next;
  logic [DRP_AW-1:0] r_daddr,      w_daddr_next;
  logic [DRP_DW-1:0] r_data_out,   w_data_out_next;
  logic [7:0]        r_data_addr,  w_data_addr_next;
  logic              r_data_ready, w_data_ready_next;
  logic              r_busy,       w_busy_next;
  logic              r_timeout,    w_timeout_next;
  logic [7:0]        r_err_count,  w_err_count_next;
  logic              r_overrun,    w_overrun_next;

  // Decoded events
  logic w_expire;
  logic w_in_wait;
  logic w_busy_state;
  logic w_capture;
  logic w_abort;
  logic w_read_done;

  assign w_in_wait    = (r_state == ST_WAIT_DRDY);
  assign w_busy_state = (r_state != ST_WAIT_EOC);
  // DRDY beats a simultaneous watchdog expiry
  assign w_capture    = w_in_wait && drp_drdy;
  assign w_abort      = w_in_wait && !drp_drdy && w_expire;
  assign w_read_done  = w_capture || w_abort;

  drp_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_state_next == ST_ISSUE),
    .i_count (w_busy_state),
    .o_expire(w_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_EOC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a completed or aborted read chains straight into the
  // next one when another conversion is already waiting
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_EOC: begin
        if (eoc_in || r_pending) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT_DRDY;
      end
      ST_WAIT_DRDY: begin
        if (w_read_done) begin
          w_state_next = (r_pending || eoc_in) ? ST_ISSUE : ST_WAIT_EOC;
        end
      end
      default: begin
        w_state_next = ST_WAIT_EOC;
      end
    endcase
  end

  // Output/datapath next values, all registered below
  always_comb begin
    w_chan_next       = w_capture ? other_chan(r_chan, ADDR_A, ADDR_B) : r_chan;
    w_den_next        = (w_state_next == ST_ISSUE);
    w_daddr_next      = w_den_next ? w_chan_next[DRP_AW-1:0] : r_daddr;
    w_data_out_next   = w_capture ? drp_do : r_data_out;
    w_data_addr_next  = w_capture ? r_chan : r_data_addr;
    w_data_ready_next = w_capture;
    w_timeout_next    = w_abort;
    w_err_count_next  = r_err_count;
    if (w_abort && (r_err_count != ERR_MAX)) begin
      w_err_count_next = r_err_count + 8'd1;
    end
    w_busy_next       = (w_state_next != ST_WAIT_EOC);
    w_overrun_next    = r_overrun | (w_busy_state && eoc_in && r_pending);
    // One request is consumed per trip into ISSUE; a second one stays queued
    w_pending_next    = r_pending;
    case (r_state)
      ST_WAIT_EOC:  w_pending_next = 1'b0;
      ST_ISSUE:     w_pending_next = r_pending | eoc_in;
      ST_WAIT_DRDY: w_pending_next = w_read_done ? (r_pending & eoc_in)
                                                 : (r_pending | eoc_in);
      default:      w_pending_next = 1'b0;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan       <= ADDR_A;
      r_pending    <= 1'b0;
      r_den        <= 1'b0;
      r_daddr      <= '0;
      r_data_out   <= '0;
      r_data_addr  <= '0;
      r_data_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
      r_err_count  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_chan       <= w_chan_next;
      r_pending    <= w_pending_next;
      r_den        <= w_den_next;
      r_daddr      <= w_daddr_next;
      r_data_out   <= w_data_out_next;
      r_data_addr  <= w_data_addr_next;
      r_data_ready <= w_data_ready_next;
      r_busy       <= w_busy_next;
      r_timeout    <= w_timeout_next;
      r_err_count  <= w_err_count_next;
      r_overrun    <= w_overrun_next;
    end
  end

  assign drp_den     = r_den;
  assign drp_dwe     = 1'b0;
  assign drp_daddr   = r_daddr;
  assign drp_di      = '0;
  assign data_out    = r_data_out;
  assign data_addr   = r_data_addr;
  assign data_ready  = r_data_ready;
  assign busy        = r_busy;
  assign timeout_err = r_timeout;
  assign err_count   = r_err_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench for xadc_drp_sequencer: a per-cycle vector table for
// the normal read flow plus hand-written timeout, saturation and reset cases.
module tb_xadc_drp_sequencer;

  logic        clk;
  logic        rst_n;
  logic        eoc_in;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic [15:0] data_out;
  logic [7:0]  data_addr;
  logic        data_ready;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  err_count;
  logic        overrun;

  int n_tests;
  int n_fail;

  xadc_drp_sequencer #(
    .ADDR_A (8'h13),
    .ADDR_B (8'h1B),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .eoc_in     (eoc_in),
    .drp_den    (drp_den),
    .drp_dwe    (drp_dwe),
    .drp_daddr  (drp_daddr),
    .drp_di     (drp_di),
    .drp_do     (drp_do),
    .drp_drdy   (drp_drdy),
    .data_out   (data_out),
    .data_addr  (data_addr),
    .data_ready (data_ready),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_count  (err_count),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row: inputs driven during a cycle and outputs expected in it
  typedef struct {
    logic        eoc;
    logic        drdy;
    logic [15:0] din;
    logic        den;
    logic [6:0]  daddr;
    logic        ready;
    logic [15:0] dout;
    logic [7:0]  daddr_out;
    logic        busy;
    logic        ovr;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs just after the rising edge, then move to mid-cycle to sample
  task automatic cyc(input logic e, input logic d, input logic [15:0] v);
    @(posedge clk);
    #1;
    eoc_in   = e;
    drp_drdy = d;
    drp_do   = v;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_den"},   32'(drp_den), 32'd0);
    check({tag, "_daddr"}, 32'(drp_daddr), 32'd0);
    check({tag, "_dout"},  32'(data_out), 32'd0);
    check({tag, "_daddr_out"}, 32'(data_addr), 32'd0);
    check({tag, "_ready"}, 32'(data_ready), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_terr"},  32'(timeout_err), 32'd0);
    check({tag, "_errcnt"}, 32'(err_count), 32'd0);
    check({tag, "_ovr"},   32'(overrun), 32'd0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    eoc_in   = 1'b0;
    drp_drdy = 1'b0;
    drp_do   = 16'h0000;

    //           eoc  drdy din       den  daddr  rdy  dout      aout   busy ovr
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 7'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'h13, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h13, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h13, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'hABC0, 1'b0, 7'h13, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h13, 1'b1, 16'hABC0, 8'h13, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 7'h13, 1'b0, 16'hABC0, 8'h13, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'h1B, 1'b0, 16'hABC0, 8'h13, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'h1230, 1'b0, 7'h1B, 1'b0, 16'hABC0, 8'h13, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h1B, 1'b1, 16'h1230, 8'h1B, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 7'h1B, 1'b0, 16'h1230, 8'h1B, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'h13, 1'b0, 16'h1230, 8'h1B, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 7'h13, 1'b0, 16'h1230, 8'h1B, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 7'h13, 1'b0, 16'h1230, 8'h1B, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 16'h4560, 1'b0, 7'h13, 1'b0, 16'h1230, 8'h1B, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'h1B, 1'b1, 16'h4560, 8'h13, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h1B, 1'b0, 16'h4560, 8'h13, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 16'h7890, 1'b0, 7'h1B, 1'b0, 16'h4560, 8'h13, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'h13, 1'b1, 16'h7890, 8'h1B, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 16'h1110, 1'b0, 7'h13, 1'b0, 16'h7890, 8'h1B, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h13, 1'b1, 16'h1110, 8'h13, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 16'hFFF0, 1'b0, 7'h13, 1'b0, 16'h1110, 8'h13, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h13, 1'b0, 16'h1110, 8'h13, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_dwe", 32'(drp_dwe), 32'd0);
    check("reset_di",  32'(drp_di), 32'd0);
    rst_n = 1'b1;

    // Table: basic read, alternation, double eoc with overrun, eoc+drdy
    // collision and a stray drdy while idle
    for (int k = 0; k < 23; k++) begin
      cyc(tbl[k].eoc, tbl[k].drdy, tbl[k].din);
      $display("[TB] row %0d: den=%0b daddr=%h rdy=%0b dout=%h aout=%h busy=%0b ovr=%0b",
               k, drp_den, drp_daddr, data_ready, data_out, data_addr, busy, overrun);
      check($sformatf("row%0d_den", k),   32'(drp_den),    32'(tbl[k].den));
      check($sformatf("row%0d_daddr", k), 32'(drp_daddr),  32'(tbl[k].daddr));
      check($sformatf("row%0d_ready", k), 32'(data_ready), 32'(tbl[k].ready));
      check($sformatf("row%0d_dout", k),  32'(data_out),   32'(tbl[k].dout));
      check($sformatf("row%0d_aout", k),  32'(data_addr),  32'(tbl[k].daddr_out));
      check($sformatf("row%0d_busy", k),  32'(busy),       32'(tbl[k].busy));
      check($sformatf("row%0d_ovr", k),   32'(overrun),    32'(tbl[k].ovr));
      check($sformatf("row%0d_terr", k),  32'(timeout_err), 32'd0);
      check($sformatf("row%0d_dwe", k),   32'(drp_dwe),    32'd0);
    end

    // Reset in the middle of a read (channel currently 0x1B)
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    check("rstmid_den", 32'(drp_den), 32'd1);
    check("rstmid_daddr", 32'(drp_daddr), 32'h1B);
    cyc(1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    #1;
    check_all_zero("rstmid_async");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 16'hDEAD);
    check("rstmid_late_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000);
    $display("[TB] late drdy after reset: rdy=%0b dout=%h", data_ready, data_out);
    check_all_zero("rstmid_after");
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    check("rstmid_next_den", 32'(drp_den), 32'd1);
    check("rstmid_next_daddr", 32'(drp_daddr), 32'h13);
    cyc(1'b0, 1'b1, 16'h2220);
    cyc(1'b0, 1'b0, 16'h0000);
    check("rstmid_read_ready", 32'(data_ready), 32'd1);
    check("rstmid_read_dout", 32'(data_out), 32'h2220);
    check("rstmid_read_aout", 32'(data_addr), 32'h13);

    // Fresh reset, then a single watchdog timeout
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 16'h0000);          // eoc at t0, den expected at t0+1
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 1'b0, 16'h0000);
      check($sformatf("to_den_c%0d", i),  32'(drp_den),     32'(i == 1));
      check($sformatf("to_terr_c%0d", i), 32'(timeout_err), 32'(i == 17));
      check($sformatf("to_ready_c%0d", i), 32'(data_ready), 32'd0);
    end
    $display("[TB] timeout: err_count=%0d dout=%h", err_count, data_out);
    check("to_errcnt", 32'(err_count), 32'd1);
    check("to_dout_held", 32'(data_out), 32'd0);
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    check("to_retry_den", 32'(drp_den), 32'd1);
    check("to_retry_daddr", 32'(drp_daddr), 32'h13);

    // Let that retry time out as well, then keep going to 300 timeouts
    begin
      logic seen;
      for (int n = 2; n <= 300; n++) begin
        if (n > 2) cyc(1'b1, 1'b0, 16'h0000);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
          cyc(1'b0, 1'b0, 16'h0000);
          if (timeout_err) seen = 1'b1;
        end
        check($sformatf("sat_timeout_%0d", n), 32'(seen), 32'd1);
        if (!seen) break;
      end
    end
    cyc(1'b0, 1'b0, 16'h0000);
    $display("[TB] after 300 timeouts: err_count=%0d", err_count);
    check("sat_errcnt", 32'(err_count), 32'd255);
    check("sat_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
